// File: rtl/beq_truth_sweeper.sv
// beq_truth_sweeper: steps A,C,B,D through all 16 vectors, holds each for
// DWELL cycles, captures Z into a truth table and compares it to EXPECTED.
//   in : clk, rst_n, start, abort, Z
//   out: A, C, B, D, busy, done, pass, truth[15:0], mismatch[15:0]
module beq_truth_sweeper #(
  parameter int          DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        Z,
  output logic        A,
  output logic        C,
  output logic        B,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth,
  output logic [15:0] mismatch
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $fatal(1, "beq_truth_sweeper: DWELL must be 1..255");
  end

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        busy_nxt, done_nxt, pass_nxt;
  logic [15:0] truth_nxt, mism_nxt;
  logic [15:0] truth_cap;

  // idx is itself a register, so the drives carry no input path.
  assign A = idx[3];
  assign C = idx[2];
  assign B = idx[1];
  assign D = idx[0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    truth_nxt = truth;
    mism_nxt  = mismatch;
    // Table as it looks once this edge's sample lands; the last vector's
    // bit must be included in the final compare.
    truth_cap      = truth;
    truth_cap[idx] = Z;
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = 4'd0;
      cnt_nxt   = 8'd0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      pass_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = RUN;
            idx_nxt   = 4'd0;
            cnt_nxt   = 8'd0;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
            truth_nxt = 16'd0;
            mism_nxt  = 16'd0;
          end
        end
        RUN: begin
          if (cnt < LAST) begin
            cnt_nxt = cnt + 8'd1;
          end else begin
            truth_nxt = truth_cap;
            if (idx != 4'hF) begin
              idx_nxt = idx + 4'd1;
              cnt_nxt = 8'd0;
            end else begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              pass_nxt  = (truth_cap == EXPECTED);
              mism_nxt  = truth_cap ^ EXPECTED;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      cnt      <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      truth    <= 16'd0;
      mismatch <= 16'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      truth    <= truth_nxt;
      mismatch <= mism_nxt;
    end
  end

endmodule

// File: tb/tb_beq_truth_sweeper.sv
// tb_beq_truth_sweeper: three sweepers (DWELL 4/1/3) driving table-based
// equation blocks; results checked against a table-lookup model.
module tb_beq_truth_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [2:0]  abort = '0;
  logic [2:0]  z, a, b, c, d, busy, done, pass;
  logic [15:0] truth [3];
  logic [15:0] mism  [3];
  logic [15:0] fn    [3];

  int          dw [3] = '{4, 1, 3};
  logic [15:0] em [3] = '{16'hCC00, 16'hCC00, 16'hFFFF};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Equation block under test: Z is a lookup of the 4-bit vector.
  always_comb begin
    for (int i = 0; i < 3; i++)
      z[i] = fn[i][{a[i], c[i], b[i], d[i]}];
  end

  beq_truth_sweeper #(.DWELL(4), .EXPECTED(16'hCC00)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .Z(z[0]), .A(a[0]), .C(c[0]), .B(b[0]), .D(d[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .truth(truth[0]), .mismatch(mism[0]));

  beq_truth_sweeper #(.DWELL(1), .EXPECTED(16'hCC00)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .Z(z[1]), .A(a[1]), .C(c[1]), .B(b[1]), .D(d[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .truth(truth[1]), .mismatch(mism[1]));

  beq_truth_sweeper #(.DWELL(3), .EXPECTED(16'hFFFF)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .Z(z[2]), .A(a[2]), .C(c[2]), .B(b[2]), .D(d[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .truth(truth[2]), .mismatch(mism[2]));

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] vec(input int u);
    return {12'd0, a[u], c[u], b[u], d[u]};
  endfunction

  task automatic chk_zero(input int u);
    chk($sformatf("u%0d zero vec", u), vec(u), 16'd0);
    chk($sformatf("u%0d zero busy", u), busy[u], 16'd0);
    chk($sformatf("u%0d zero done", u), done[u], 16'd0);
    chk($sformatf("u%0d zero pass", u), pass[u], 16'd0);
    chk($sformatf("u%0d zero truth", u), truth[u], 16'd0);
    chk($sformatf("u%0d zero mism", u), mism[u], 16'd0);
  endtask

  // Full sweep on unit u; optional extra start at cycle sa and abort at
  // cycle ab (cycle j = time just after edge t0+j).
  task automatic sweep(input int u, input int sa, input int ab);
    int w;
    int nb;
    logic [16:0] m;
    w = dw[u];
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    for (int j = 0; j < 16 * w; j++) begin
      chk($sformatf("u%0d busy c%0d", u, j), busy[u], 16'd1);
      chk($sformatf("u%0d done c%0d", u, j), done[u], 16'd0);
      chk($sformatf("u%0d vec c%0d", u, j), vec(u), 16'(j / w));
      if (j == 0)
        chk($sformatf("u%0d truth clr", u), truth[u], 16'd0);
      if (j == sa) start[u] = 1'b1;
      if (j == ab) abort[u] = 1'b1;
      @(posedge clk);
      #1;
      start[u] = 1'b0;
      abort[u] = 1'b0;
      if (j == ab) begin
        nb = (j + 1) / w;
        m  = (17'd1 << nb) - 17'd1;
        chk($sformatf("u%0d abort busy", u), busy[u], 16'd0);
        chk($sformatf("u%0d abort done", u), done[u], 16'd0);
        chk($sformatf("u%0d abort pass", u), pass[u], 16'd0);
        chk($sformatf("u%0d abort vec", u), vec(u), 16'd0);
        chk($sformatf("u%0d abort truth", u), truth[u], fn[u] & m[15:0]);
        return;
      end
    end
    chk($sformatf("u%0d end busy", u), busy[u], 16'd0);
    chk($sformatf("u%0d end done", u), done[u], 16'd1);
    chk($sformatf("u%0d end vec", u), vec(u), 16'hF);
    chk($sformatf("u%0d end truth", u), truth[u], fn[u]);
    chk($sformatf("u%0d end pass", u), pass[u], 16'(fn[u] == em[u]));
    chk($sformatf("u%0d end mism", u), mism[u], fn[u] ^ em[u]);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("u%0d hold vec", u), vec(u), 16'hF);
    chk($sformatf("u%0d hold done", u), done[u], 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) fn[i] = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i);
    @(negedge clk);
    rst_n = 1'b1;

    fn[0] = 16'hCC00;
    sweep(0, -1, -1);
    fn[1] = 16'hAAAA;
    sweep(1, -1, -1);
    fn[2] = 16'hFFFF;
    sweep(2, -1, -1);
    sweep(2, -1, -1);

    fn[0] = 16'($urandom);
    sweep(0, 21, 37);

    fn[0] = 16'($urandom);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("u0 pre-reset vec", vec(0), 16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    fn[0] = 16'hCC00;
    sweep(0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      fn[1] = 16'($urandom);
      sweep(1, -1, -1);
      fn[0] = 16'($urandom);
      sweep(0, -1, -1);
    end
    fn[2] = 16'($urandom);
    sweep(2, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
